// File: rtl/probe_conditioner_if.sv
// probe_conditioner_if: groups the gate, filter-exponent and probe lanes that
// connect the probe pins to the conditioner and on to the correlator.
interface probe_conditioner_if #(
  parameter int N_PROBE        = 4,
  parameter int MAX_FILTER_EXP = 4,
  parameter int FEXP_W         = $clog2(MAX_FILTER_EXP + 1)
);
  logic               i_cg;
  logic [FEXP_W-1:0]  i_filterExp;
  logic [N_PROBE-1:0] i_probe;
  logic [N_PROBE-1:0] o_probe;
  logic [N_PROBE-1:0] o_toggle;
  logic [N_PROBE-1:0] o_activity;

  // Driver side: owns the gate, the filter setting and the raw pins.
  modport master (
    output i_cg, i_filterExp, i_probe,
    input  o_probe, o_toggle, o_activity
  );

  // Conditioner side.
  modport slave (
    input  i_cg, i_filterExp, i_probe,
    output o_probe, o_toggle, o_activity
  );
endinterface

// File: rtl/probe_conditioner.sv
// probe_conditioner: per-lane synchroniser, runtime-selectable deglitch
// filter and one-cycle toggle strobe for the correlator probe pins.
// Optional activity stretcher enabled by defining PROBE_CONDITIONER_STRETCH_EN.
module probe_conditioner #(
  parameter int N_PROBE        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int MAX_FILTER_EXP = 4,
  parameter int STRETCH_EXP    = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  probe_conditioner_if.slave bus
);
  localparam int FEXP_W = $clog2(MAX_FILTER_EXP + 1);
  localparam int CNT_W  = MAX_FILTER_EXP + 1;

  logic [N_PROBE-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0]   r_cnt [N_PROBE];
  logic [N_PROBE-1:0] r_probe;
  logic [N_PROBE-1:0] r_toggle;
  logic [FEXP_W-1:0]  r_fexp;
  logic               r_fexp_chg;

  logic [FEXP_W-1:0]  w_fexp;
  logic [CNT_W-1:0]   w_thresh;
  logic [N_PROBE-1:0] w_sync_out;
  logic [CNT_W-1:0]   w_cnt_inc [N_PROBE];
  logic [N_PROBE-1:0] w_fire;

  // Clamp the requested exponent so the threshold never exceeds 2**MAX.
  always_comb begin
    if (bus.i_filterExp > FEXP_W'(MAX_FILTER_EXP)) begin
      w_fexp = FEXP_W'(MAX_FILTER_EXP);
    end else begin
      w_fexp = bus.i_filterExp;
    end
  end

  assign w_thresh   = CNT_W'(1) << r_fexp;
  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Per lane: decide whether the synchronised level has been stable long enough.
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < N_PROBE; i++) begin
      w_cnt_inc[i] = r_cnt[i] + CNT_W'(1);
      if (r_fexp_chg) begin
        w_fire[i] = 1'b0;
      end else if ((w_sync_out[i] != r_probe[i]) && (w_cnt_inc[i] >= w_thresh)) begin
        w_fire[i] = 1'b1;
      end else begin
        w_fire[i] = 1'b0;
      end
    end
  end

  // Synchroniser chain, filter-exponent register and per-lane deglitch counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
      for (int i = 0; i < N_PROBE; i++) begin
        r_cnt[i] <= '0;
      end
      r_probe    <= '0;
      r_toggle   <= '0;
      r_fexp     <= '0;
      r_fexp_chg <= 1'b0;
    end else if (bus.i_cg) begin
      r_sync[0] <= bus.i_probe;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_fexp     <= w_fexp;
      r_fexp_chg <= (w_fexp != r_fexp);
      for (int i = 0; i < N_PROBE; i++) begin
        // A new threshold restarts every lane; a matching level drops any partial count.
        if (r_fexp_chg || (w_sync_out[i] == r_probe[i])) begin
          r_cnt[i]    <= '0;
          r_toggle[i] <= 1'b0;
        end else if (w_fire[i]) begin
          r_probe[i]  <= w_sync_out[i];
          r_cnt[i]    <= '0;
          r_toggle[i] <= 1'b1;
        end else begin
          r_cnt[i]    <= w_cnt_inc[i];
          r_toggle[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.o_probe  = r_probe;
  // The strobe register holds while gated, so mask it to keep it one enabled cycle wide.
  assign bus.o_toggle = r_toggle & {N_PROBE{bus.i_cg}};

`ifdef PROBE_CONDITIONER_STRETCH_EN
  logic [STRETCH_EXP-1:0] r_stretch [N_PROBE];
  logic [N_PROBE-1:0]     r_activity;

  // Activity stretcher: reload on each strobe, count down to zero otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_PROBE; i++) begin
        r_stretch[i] <= '0;
      end
      r_activity <= '0;
    end else if (bus.i_cg) begin
      for (int i = 0; i < N_PROBE; i++) begin
        if (w_fire[i]) begin
          r_stretch[i]  <= '1;
          r_activity[i] <= 1'b1;
        end else if (r_stretch[i] != '0) begin
          r_stretch[i]  <= r_stretch[i] - STRETCH_EXP'(1);
          r_activity[i] <= (r_stretch[i] != STRETCH_EXP'(1));
        end else begin
          r_activity[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.o_activity = r_activity;
`else
  assign bus.o_activity = '0;
`endif

endmodule

// File: doc/probe_conditioner.md
Name: probe_conditioner

Overview:
- Front-end for the correlator's raw probe pins; its outputs feed the probe crossbar/correlator `i_probe` bus directly.
- Per probe, it synchronises the asynchronous input into `i_clk` with a multi-flop chain.
- It then applies a runtime-selectable deglitch filter so only stable levels propagate.
- It emits a single-cycle toggle strobe per probe for activity monitoring.

Parameters:
- N_PROBE, 4, number of probe lanes (2..256).
- SYNC_STAGES, 2, synchroniser flops per lane (2..4).
- MAX_FILTER_EXP, 4, maximum deglitch exponent; filter length is 2**filterExp cycles.
- STRETCH_EXP, 20, activity stretch length exponent (used only with the optional feature).

Ports:
- i_clk  input  1  single system clock (48MHz).
- i_rst  input  1  asynchronous, active-high reset.
- i_cg  input  1  clock gate; 1 = registers advance, 0 = all state holds.
- i_filterExp  input  $clog2(MAX_FILTER_EXP+1)  deglitch exponent; values > MAX_FILTER_EXP are clamped to MAX_FILTER_EXP.
- i_probe  input  N_PROBE  raw asynchronous probe pins.
- o_probe  output  N_PROBE  conditioned, registered probe levels.
- o_toggle  output  N_PROBE  1-cycle strobe on the cycle o_probe[i] changes.
- o_activity  output  N_PROBE  stretched activity indicator (optional feature).

Behaviour:
- Reset (async, i_rst=1): all of the following clear to 0 immediately, independent of i_clk and i_cg:
  - sync flops, counters, o_probe, o_toggle, o_activity.
  - registered filterExp copy.
- Reset asserted mid-count discards partial counts; there is no metastable output during reset.
- i_cg=0: no register changes.
  - o_toggle is forced 0 while i_cg=0.
  - A pending stable level is not counted while gated.
- Synchroniser: s[i] = i_probe[i] delayed by SYNC_STAGES enabled cycles.
- Threshold T = 2**min(i_filterExp, MAX_FILTER_EXP).
- Counter cnt[i], width MAX_FILTER_EXP+1 bits, updates on each enabled cycle:
  - s[i]==o_probe[i]: cnt <= 0.
  - s[i]!=o_probe[i] and cnt+1 >= T: o_probe[i] <= s[i], cnt <= 0, o_toggle[i] <= 1.
  - Otherwise: cnt <= cnt+1, o_toggle[i] <= 0.
- Saturation: cnt never exceeds T-1, so it cannot wrap.
- Latency: a raw edge held stable reaches o_probe exactly SYNC_STAGES + T enabled cycles after the first sampling edge.
  - filterExp=0 gives SYNC_STAGES+1 cycles.
- Glitch rejection: any pulse shorter than T cycles (after synchronisation) never reaches o_probe. Its partial count is discarded when s returns to o_probe.
- filterExp change:
  - i_filterExp is registered; all counters clear on the cycle after the registered value changes. No toggle occurs on that cycle.
  - Counting restarts from 0 under the new T.
- Simultaneous events: lanes are fully independent; any number of lanes may toggle in the same cycle.
- o_toggle[i] is high for exactly one enabled cycle per o_probe[i] transition, aligned with the new o_probe value.
- Width rules: N_PROBE=1 is not supported; i_filterExp width is derived as above; no arithmetic overflow is possible by construction.

Optional Feature:
- Macro: PROBE_CONDITIONER_STRETCH_EN.
- Defined:
  - Per lane, a STRETCH_EXP-bit down-counter loads all-ones on o_toggle[i] and otherwise decrements to 0 while i_cg=1.
  - o_activity[i] = (counter != 0), registered.
  - A new toggle during the stretch reloads the counter.
  - Reset clears the counter.
- Undefined: o_activity is tied to 0; no stretch counters are synthesised.

Test Plan:
- Reset, then i_probe=4'b0000 static for 100 cycles, filterExp=0 -> o_probe=0, o_toggle=0 throughout; o_probe=0 during and immediately after async i_rst pulse asserted off-edge.
- filterExp=3, rising edge on i_probe[0], held -> o_probe[0] rises exactly 2+8=10 cycles after the sampling edge; o_toggle[0] high for that one cycle; other lanes unchanged.
- filterExp=3, 7-cycle high pulse on i_probe[1] -> o_probe[1] stays 0, o_toggle[1] never asserts; an 8-cycle pulse -> o_probe[1] high for exactly 8 cycles.
- i_filterExp=7 (clamped to 4) -> latency 2+16=18; change filterExp 4->1 mid-count -> counter clears, o_probe follows 2 cycles after the restart.
- i_cg=0 for 5 cycles mid-filter -> latency extended by exactly 5 cycles, o_toggle stays 0 while gated; i_rst mid-count -> o_probe=0, next edge takes full latency.
- With PROBE_CONDITIONER_STRETCH_EN, STRETCH_EXP=4: one toggle -> o_activity high 15 cycles after the registered strobe; second toggle at cycle 10 -> reload, high 15 more; without macro o_activity==0 always.
